// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the mapped-memory request sequencer.
// Holds the FSM state type, the open-bus read value and the default wait limit.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic [7:0] MEM_OPEN_BUS    = 8'hFF;
    localparam int         DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_req_timer.sv
// Saturating 8-bit wait counter for an outstanding memory request.
// expire is high while the count sits at TIMEOUT-1; it never wraps.
module mem_req_timer
    import mem_seq_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST)) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign expire = (count_reg == LAST);

endmodule

// File: rtl/slot_mem_req_seq.sv
// Converts one mapped CPU access into a single req/ack memory transaction,
// stalling the CPU until completion and holding read data until mreq drops.
module slot_mem_req_seq
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mreq,
    input  logic              rd,
    input  logic              wr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic [ADDR_W-1:0] map_addr,
    input  logic              map_ram_cs,
    output logic              cpu_wait,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              rd_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              timeout_err
);

    localparam logic [DATA_W-1:0] OPEN_BUS = DATA_W'(MEM_OPEN_BUS);

    seq_state_t state_reg, state_next;

    logic              start;
    logic              load;
    logic              complete;
    logic              abort;
    logic              release_access;
    logic              expire;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [DATA_W-1:0] cpu_dout_reg;
    logic              rd_valid_reg;
    logic              timeout_err_reg;

    // Gated by reset_n so a held mreq cannot raise cpu_wait while in reset.
    assign start = reset_n && (state_reg == IDLE) && mreq && map_ram_cs && (rd || wr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (mem_ack || expire) state_next = DONE;
            DONE:    if (!mreq) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cpu_wait       = 1'b0;
        load           = 1'b0;
        complete       = 1'b0;
        abort          = 1'b0;
        release_access = 1'b0;
        case (state_reg)
            IDLE: begin
                cpu_wait = start;
                load     = start;
            end
            BUSY: begin
                cpu_wait = 1'b1;
                complete = mem_ack;
                abort    = !mem_ack && expire;
            end
            DONE:    release_access = !mreq;
            default: ;
        endcase
    end

    mem_req_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (load),
        .enable  (state_reg == BUSY),
        .expire  (expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            cpu_dout_reg    <= OPEN_BUS;
            rd_valid_reg    <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (load) begin
                mem_req_reg   <= 1'b1;
                mem_we_reg    <= wr;
                mem_addr_reg  <= map_addr;
                mem_wdata_reg <= cpu_din;
            end
            if (complete) begin
                mem_req_reg <= 1'b0;
                if (!mem_we_reg) begin
                    cpu_dout_reg <= mem_rdata;
                    rd_valid_reg <= 1'b1;
                end
            end
            if (abort) begin
                mem_req_reg     <= 1'b0;
                cpu_dout_reg    <= OPEN_BUS;
                timeout_err_reg <= 1'b1;
                if (!mem_we_reg) begin
                    rd_valid_reg <= 1'b1;
                end
            end
            if (release_access) begin
                rd_valid_reg <= 1'b0;
            end
        end
    end

    assign mem_req     = mem_req_reg;
    assign mem_we      = mem_we_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign cpu_dout    = cpu_dout_reg;
    assign rd_valid    = rd_valid_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_slot_mem_req_seq.sv
// Bench for slot_mem_req_seq: directed and random accesses checked against
// a transaction-level model (expected stall, request length, data, error flag).
module tb_slot_mem_req_seq;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mreq = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  cpu_din = '0;
    logic [26:0] map_addr = '0;
    logic        map_ram_cs = 1'b0;
    logic        cpu_wait;
    logic [7:0]  cpu_dout;
    logic        rd_valid;
    logic        mem_req;
    logic        mem_we;
    logic [26:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        timeout_err;

    int tests = 0;
    int failed = 0;
    int n_acc = 0;

    // Transaction-level model of what the CPU side should observe.
    logic [7:0] model_dout = 8'hFF;
    logic       model_rv = 1'b0;
    logic       model_err = 1'b0;

    slot_mem_req_seq #(
        .ADDR_W  (27),
        .DATA_W  (8),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mreq        (mreq),
        .rd          (rd),
        .wr          (wr),
        .cpu_din     (cpu_din),
        .map_addr    (map_addr),
        .map_ram_cs  (map_ram_cs),
        .cpu_wait    (cpu_wait),
        .cpu_dout    (cpu_dout),
        .rd_valid    (rd_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ack_dly: BUSY cycle (1-based) in which mem_ack is given; 0 = never.
    task automatic do_access(input bit w, input bit both, input logic [26:0] a,
                             input logic [7:0] d, input int ack_dly,
                             input logic [7:0] rdat, input int hold);
        bit to;
        int exp_reqs;
        int waits;
        int reqs;
        bit done;
        bit stable;
        bit hold_ok;
        to       = !(ack_dly >= 1 && ack_dly <= TMO);
        exp_reqs = to ? TMO : ack_dly;

        @(negedge clk);
        mreq = 1'b1; rd = !w || both; wr = w; map_addr = a; cpu_din = d; map_ram_cs = 1'b1;
        #1;
        check("start_wait", {31'b0, cpu_wait}, 32'd1);
        check("start_req", {31'b0, mem_req}, 32'd0);

        waits = 1; reqs = 0; done = 1'b0; stable = 1'b1;
        for (int c = 0; c < TMO + 20 && !done; c++) begin
            @(negedge clk);
            // Upstream inputs wander during the transaction; the request must not.
            map_addr = 27'($urandom);
            cpu_din  = 8'($urandom);
            if (mem_req) begin
                reqs++;
                stable &= (mem_we === w) && (mem_addr === a) && (mem_wdata === d);
                mem_ack   = (reqs == ack_dly);
                mem_rdata = (reqs == ack_dly) ? rdat : 8'($urandom);
            end else begin
                mem_ack = 1'b0;
            end
            #1;
            if (cpu_wait) waits++;
            else done = 1'b1;
        end
        check("completed", {31'b0, done}, 32'd1);
        check("req_cycles", reqs, exp_reqs);
        check("wait_cycles", waits, exp_reqs + 1);
        check("req_stable", {31'b0, stable}, 32'd1);

        if (to) model_err = 1'b1;
        if (!w) begin
            model_dout = to ? 8'hFF : rdat;
            model_rv   = 1'b1;
        end else if (to) begin
            model_dout = 8'hFF;
        end
        check("done_dout", {24'b0, cpu_dout}, {24'b0, model_dout});
        check("done_rv", {31'b0, rd_valid}, {31'b0, model_rv});
        check("done_err", {31'b0, timeout_err}, {31'b0, model_err});

        // CPU keeps mreq high; stray acks must not start or alter anything.
        hold_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = 8'($urandom);
            #1;
            hold_ok &= (cpu_wait === 1'b0) && (mem_req === 1'b0) &&
                       (rd_valid === model_rv) && (cpu_dout === model_dout);
        end
        check("hold_stable", {31'b0, hold_ok}, 32'd1);

        @(negedge clk);
        mem_ack = 1'b0; mreq = 1'b0; rd = 1'b0; wr = 1'b0;
        #1;
        check("end_wait", {31'b0, cpu_wait}, 32'd0);
        @(negedge clk);
        #1;
        model_rv = 1'b0;
        check("end_rv", {31'b0, rd_valid}, {31'b0, model_rv});
        check("end_dout", {24'b0, cpu_dout}, {24'b0, model_dout});
        n_acc++;
        $display("[TB] access %0d: %s addr=%h ack_dly=%0d hold=%0d dout=%h err=%0d",
                 n_acc, w ? "write" : "read", a, ack_dly, hold, model_dout, model_err);
    endtask

    initial begin
        logic [26:0] ra;
        bit          rw;
        int          rack;

        #12;
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_wait", {31'b0, cpu_wait}, 32'd0);
        check("rst_dout", {24'b0, cpu_dout}, 32'hFF);
        check("rst_addr", {5'b0, mem_addr}, 32'd0);
        check("rst_err", {31'b0, timeout_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        do_access(1'b0, 1'b0, 27'h0012345, 8'h00, 1, 8'hA5, 2);
        do_access(1'b1, 1'b0, 27'h0006000, 8'h3C, 5, 8'h00, 1);

        // Unmapped access: no request, no stall, data untouched.
        @(negedge clk);
        mreq = 1'b1; rd = 1'b1; map_ram_cs = 1'b0; map_addr = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("unmap_wait", {31'b0, cpu_wait}, 32'd0);
            check("unmap_req", {31'b0, mem_req}, 32'd0);
        end
        check("unmap_dout", {24'b0, cpu_dout}, {24'b0, model_dout});
        mreq = 1'b0; rd = 1'b0;
        $display("[TB] access unmapped: no request");

        do_access(1'b0, 1'b0, 27'h1234567, 8'h00, 2, 8'h5E, 20);
        do_access(1'b1, 1'b1, 27'h0000ABC, 8'h91, 3, 8'h00, 0);
        do_access(1'b0, 1'b0, 27'h7FFFFFF, 8'h00, TMO, 8'hC3, 1);
        do_access(1'b0, 1'b0, 27'h0001000, 8'h00, 0, 8'h00, 1);
        do_access(1'b0, 1'b0, 27'h0002000, 8'h00, 1, 8'h42, 1);

        // Reset while a request is outstanding.
        @(negedge clk);
        mreq = 1'b1; rd = 1'b1; wr = 1'b0; map_ram_cs = 1'b1; map_addr = 27'h0054321;
        repeat (4) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_req", {31'b0, mem_req}, 32'd0);
        check("arst_wait", {31'b0, cpu_wait}, 32'd0);
        check("arst_rv", {31'b0, rd_valid}, 32'd0);
        check("arst_dout", {24'b0, cpu_dout}, 32'hFF);
        check("arst_err", {31'b0, timeout_err}, 32'd0);
        model_dout = 8'hFF; model_rv = 1'b0; model_err = 1'b0;
        @(negedge clk);
        mreq = 1'b0; rd = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 8'h77;
        #1;
        check("late_ack_req", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("late_ack_rv", {31'b0, rd_valid}, 32'd0);
        check("late_ack_dout", {24'b0, cpu_dout}, 32'hFF);
        $display("[TB] access reset: aborted in flight");

        for (int i = 0; i < 14; i++) begin
            rw   = 1'($urandom_range(0, 1));
            ra   = 27'($urandom);
            rack = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            do_access(rw, rw && ($urandom_range(0, 3) == 0), ra, 8'($urandom), rack,
                      8'($urandom), int'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
